// File: rtl/maze_mem_arbiter.sv
// Purpose: shares the single-port 256x1 maze/visited RAM between solver (S), loader (L) and viewer (V).
// Latency: gnt one cycle after a winning req is sampled in ARB, rvalid one cycle after gnt (write 2 cycles, read 3).
// Backpressure: requesters hold req until gnt; lock narrows eligibility to S; long waits raise sticky starve flags.
module maze_mem_arbiter #(
  parameter int AW         = 8,
  parameter int WAIT_LIMIT = 64
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          lock,
  input  logic          s_req,
  input  logic          l_req,
  input  logic          v_req,
  input  logic          s_we,
  input  logic          l_we,
  input  logic          v_we,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] l_addr,
  input  logic [AW-1:0] v_addr,
  input  logic          s_wdata,
  input  logic          l_wdata,
  output logic          s_gnt,
  output logic          l_gnt,
  output logic          v_gnt,
  output logic          s_rvalid,
  output logic          v_rvalid,
  output logic          rdata,
  output logic          s_starve,
  output logic          l_starve,
  output logic          v_starve,
  input  logic          starve_clr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wdata,
  input  logic          mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {ARB = 2'd0, ACC = 2'd1, RD = 2'd2} state_t;

  localparam logic [1:0] ID_S  = 2'd0;
  localparam logic [1:0] ID_L  = 2'd1;
  localparam logic [1:0] ID_V  = 2'd2;
  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      id_q;
  logic [2:0]      gnt_q;
  logic            s_rvalid_q;
  logic            v_rvalid_q;
  logic            mem_en_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_wdata_q;
  logic            busy_q;

  logic [2:0][7:0] wcnt_q;
  logic [2:0][7:0] wcnt_d;
  logic [2:0]      starve_q;
  logic [2:0]      starve_d;

  logic [2:0]      req_all;
  logic [2:0]      elig;
  logic            win_vld;
  logic [1:0]      win_id;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic            win_wdata;
  logic [1:0]      ptr_nxt;

  // Requester index 'off' positions after 'base' in the S, L, V ring.
  function automatic logic [1:0] rot_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  assign req_all = {v_req, l_req, s_req};
  // Under lock the solver owns the RAM; L and V keep waiting (and counting).
  assign elig    = lock ? {2'b00, s_req} : req_all;

  // Pick the first eligible requester at or after the round-robin pointer.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      if (elig[rot_idx(ptr_q, k)]) begin
        win_vld = 1'b1;
        win_id  = rot_idx(ptr_q, k);
      end
    end
  end

  // Select the winner's command; L always writes, V always reads and has no write data.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = v_addr;
    win_wdata = 1'b0;
    case (win_id)
      ID_S: begin
        win_we    = s_we;
        win_addr  = s_addr;
        win_wdata = s_wdata;
      end
      ID_L: begin
        win_we    = 1'b1;
        win_addr  = l_addr;
        win_wdata = l_wdata;
      end
      default: begin
        win_we    = 1'b0;
        win_addr  = v_addr;
        win_wdata = 1'b0;
      end
    endcase
  end

  assign ptr_nxt = (win_id == ID_V) ? ID_S : win_id + 2'd1;

  // Arbitration FSM; the RAM pins double as the latched command and are only non-zero in ACC.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ARB;
      ptr_q       <= ID_S;
      id_q        <= ID_S;
      gnt_q       <= '0;
      s_rvalid_q  <= 1'b0;
      v_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      s_rvalid_q  <= 1'b0;
      v_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (win_vld) begin
            state_q         <= ACC;
            id_q            <= win_id;
            ptr_q           <= ptr_nxt;
            gnt_q[win_id]   <= 1'b1;
            mem_en_q        <= 1'b1;
            mem_we_q        <= win_we;
            mem_addr_q      <= win_addr;
            mem_wdata_q     <= win_wdata;
            busy_q          <= 1'b1;
          end
        end
        ACC: begin
          if (mem_we_q) begin
            state_q <= ARB;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= RD;
            s_rvalid_q <= (id_q == ID_S);
            v_rvalid_q <= (id_q == ID_V);
          end
        end
        RD: begin
          state_q <= ARB;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Wait counters only advance in ARB; a winner or an idle requester restarts from zero.
  always_comb begin
    wcnt_d   = wcnt_q;
    starve_d = starve_q;
    for (int r = 0; r < 3; r++) begin
      if (!req_all[r]) begin
        wcnt_d[r] = 8'd0;
      end else if (state_q == ARB) begin
        if (win_vld && (win_id == 2'(r))) begin
          wcnt_d[r] = 8'd0;
        end else if (wcnt_q[r] != LIMIT) begin
          wcnt_d[r] = wcnt_q[r] + 8'd1;
        end
      end
      if (wcnt_d[r] == LIMIT) starve_d[r] = 1'b1;
      if (starve_clr) begin
        wcnt_d[r]   = 8'd0;
        starve_d[r] = 1'b0;
      end
    end
  end

  // Starvation counters and sticky flags.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wcnt_q   <= '0;
      starve_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      starve_q <= starve_d;
    end
  end

  assign s_gnt     = gnt_q[0];
  assign l_gnt     = gnt_q[1];
  assign v_gnt     = gnt_q[2];
  assign s_rvalid  = s_rvalid_q;
  assign v_rvalid  = v_rvalid_q;
  // The RAM answers the cycle after the read enable, which is exactly the RD cycle.
  assign rdata     = (state_q == RD) ? mem_rdata : 1'b0;
  assign s_starve  = starve_q[0];
  assign l_starve  = starve_q[1];
  assign v_starve  = starve_q[2];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
